// File: rtl/ws2812_stream_tx.sv
// ws2812_stream_tx
//   WS2812-family single-wire LED transmitter. Pixels arrive on a valid/ready
//   stream. Each pixel is sent MSB-first as return-to-zero code: every bit lasts
//   T_BIT cycles and is high for T1H ('1') or T0H ('0') cycles. A frame ends
//   after NUM_PIX pixels, or early when the source has no pixel ready at a pixel
//   boundary. The line is then held low for T_RESET cycles, and frame_done pulses.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   pix_data    pixel word, bit BITS-1 is sent first
//   pix_valid   pix_data valid
//   pix_ready   pixel accepted this cycle when pix_valid is high (combinational)
//   busy        frame in progress (sending or latch period)
//   frame_done  one-cycle pulse on the last cycle of the latch period
//   underrun    one-cycle pulse when a frame ends early for lack of data
//   dout        registered RZ line to the LEDs, idles low
module ws2812_stream_tx #(
    parameter int BITS    = 24,
    parameter int NUM_PIX = 8,
    parameter int T_BIT   = 63,
    parameter int T0H     = 21,
    parameter int T1H     = 43,
    parameter int T_RESET = 15000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] pix_data,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun,
    output logic            dout
);

    localparam int CW = (T_BIT > 1)   ? $clog2(T_BIT)   : 1;
    localparam int BW = (BITS > 1)    ? $clog2(BITS)    : 1;
    localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int RW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIX - 1);
    localparam logic [RW-1:0] LAT_LAST = RW'(T_RESET - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t          state_q;
    logic [CW-1:0]   cyc_q;
    logic [BW-1:0]   bit_q;
    logic [PW-1:0]   pix_q;
    logic [RW-1:0]   lat_q;
    logic [BITS-1:0] shreg_q;
    logic            dout_q;

    logic          bit_end, pix_end, more_pix, xfer, dout_d;
    logic [CW-1:0] cyc_d, high_len;

    assign bit_end  = (state_q == SEND) && (cyc_q == CYC_LAST);
    assign pix_end  = bit_end && (bit_q == BIT_LAST);
    assign more_pix = (pix_q != PIX_LAST);

    // Gated by rst_n so every output reads 0 while reset is held.
    assign pix_ready  = rst_n && ((state_q == IDLE) || (pix_end && more_pix));
    assign xfer       = pix_valid && pix_ready;
    assign underrun   = rst_n && pix_end && more_pix && !pix_valid;
    assign frame_done = (state_q == LATCH) && (lat_q == LAT_LAST);
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;

    // dout is registered, so it is computed for the cycle about to start:
    // within a bit, the line stays high while the next cycle index is below
    // the high time of the bit currently in the MSB.
    assign cyc_d    = cyc_q + CW'(1);
    assign high_len = shreg_q[BITS-1] ? T1H_C : T0H_C;
    assign dout_d   = (cyc_d < high_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            lat_q   <= '0;
            shreg_q <= '0;
            dout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        shreg_q <= pix_data;
                        pix_q   <= '0;
                        bit_q   <= '0;
                        cyc_q   <= '0;
                        dout_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!bit_end) begin
                        cyc_q  <= cyc_d;
                        dout_q <= dout_d;
                    end else if (bit_q != BIT_LAST) begin
                        // Every bit starts high since T0H > 0.
                        cyc_q   <= '0;
                        bit_q   <= bit_q + BW'(1);
                        shreg_q <= shreg_q << 1;
                        dout_q  <= 1'b1;
                    end else if (xfer) begin
                        // Next pixel follows with no gap on the line.
                        shreg_q <= pix_data;
                        pix_q   <= pix_q + PW'(1);
                        bit_q   <= '0;
                        cyc_q   <= '0;
                        dout_q  <= 1'b1;
                    end else begin
                        // Frame complete or source underrun.
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        lat_q   <= '0;
                        dout_q  <= 1'b0;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (lat_q == LAT_LAST) begin
                        lat_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        lat_q <= lat_q + RW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Bench for ws2812_stream_tx. Two instances: a 24-bit one with default timing
// (2 pixels per frame) and a 32-bit fast-timing one (3 pixels per frame).
// A per-instance reference computes the line from the frame timeline: t counts
// cycles from the first pixel, pixel = t / (BITS*T_BIT), bit = (t / T_BIT) % BITS.
module tb_ws2812_stream_tx;

    localparam int MAXT = 20000;

    logic clk = 1'b0;
    logic [1:0]       rst_n;
    logic [1:0]       valid;
    logic [1:0][31:0] data;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int BITS    = (g == 0) ? 24 : 32;
        localparam int NUM_PIX = (g == 0) ? 2 : 3;
        localparam int T_BIT   = (g == 0) ? 63 : 10;
        localparam int T0H     = (g == 0) ? 21 : 3;
        localparam int T1H     = (g == 0) ? 43 : 7;
        localparam int T_RESET = (g == 0) ? 15000 : 20;
        localparam int PIXLEN  = BITS * T_BIT;

        logic rdy, bsy, fd, ud, dout;

        ws2812_stream_tx #(
            .BITS(BITS), .NUM_PIX(NUM_PIX), .T_BIT(T_BIT),
            .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .pix_data(data[g][BITS-1:0]),
            .pix_valid(valid[g]), .pix_ready(rdy), .busy(bsy),
            .frame_done(fd), .underrun(ud), .dout(dout)
        );

        logic [31:0] pix_m [0:NUM_PIX-1];
        bit   obs [0:MAXT-1];
        bit   active = 1'b0;
        int   t = 0, t_cur = -1, npix = 0;
        int   done_cnt = 0, ud_cnt = 0, xfer_cnt = 0;
        int   fd_t = -1, ud_t = -1, fd_cyc = -1, xf_cyc = -1;

        always @(negedge clk) begin
            int  send_len, bi;
            bit  bv, e_rdy, e_ud, e_fd, e_dout, xf;
            if (!rst_n[g]) begin
                chk($sformatf("g%0d_reset_outputs", g), {rdy, bsy, fd, ud, dout}, 5'b0);
                active = 1'b0;
                t_cur  = -1;
            end else begin
                send_len = npix * PIXLEN;
                e_rdy = !active; e_ud = 1'b0; e_fd = 1'b0; e_dout = 1'b0;
                t_cur = active ? t : -1;
                if (active) begin
                    if (t < send_len) begin
                        bi = (t / T_BIT) % BITS;
                        bv = pix_m[t / PIXLEN][BITS-1-bi];
                        e_dout = (t % T_BIT) < (bv ? T1H : T0H);
                        if (t == send_len - 1 && npix < NUM_PIX) begin
                            e_rdy = 1'b1;
                            e_ud  = !valid[g];
                        end
                    end else begin
                        e_fd = (t == send_len + T_RESET - 1);
                    end
                end
                chk($sformatf("g%0d_outputs t=%0d {rdy,busy,fd,ud,dout}", g, t_cur),
                    {rdy, bsy, fd, ud, dout}, {e_rdy, active, e_fd, e_ud, e_dout});
                if (active && t < MAXT) obs[t] = dout;
                if (e_ud) begin ud_cnt++; ud_t = t; end
                xf = valid[g] && e_rdy;
                if (active) begin
                    if (e_fd) begin
                        active = 1'b0;
                        done_cnt++;
                        fd_t   = t;
                        fd_cyc = cyc;
                    end else begin
                        if (xf) begin
                            pix_m[npix] = data[g];
                            npix++;
                            xfer_cnt++;
                        end
                        t++;
                    end
                end else if (xf) begin
                    pix_m[0] = data[g];
                    npix = 1; t = 0; active = 1'b1;
                    xfer_cnt = 1; ud_cnt = 0; ud_t = -1; xf_cyc = cyc;
                end
            end
        end
    end

    function automatic bit rdy_of(input int g);
        return (g == 0) ? gen[0].rdy : gen[1].rdy;
    endfunction

    function automatic int done_of(input int g);
        return (g == 0) ? gen[0].done_cnt : gen[1].done_cnt;
    endfunction

    // High cycles observed in bit window k of the frame.
    function automatic int hi(input int g, input int k);
        int s = 0;
        int tb = (g == 0) ? 63 : 10;
        for (int i = k * tb; i < (k + 1) * tb; i++) s += (g == 0) ? int'(gen[0].obs[i]) : int'(gen[1].obs[i]);
        return s;
    endfunction

    // Wait for an accepted pixel; returns #1 after the accepting edge.
    task automatic wait_xfer(input int g, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (valid[g] && rdy_of(g)) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk($sformatf("g%0d_xfer_timeout", g), 1, 0);
    endtask

    // Wait for the next frame_done; returns at negedge+2 of that cycle.
    task automatic wait_frame(input int g, input int max);
        int d0 = done_of(g);
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #2;
            if (done_of(g) != d0) return;
        end
        chk($sformatf("g%0d_frame_timeout", g), 1, 0);
    endtask

    initial begin
        int d0, tot;
        bit hit;
        rst_n = 2'b00; valid = 2'b00; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", gen[0].rdy, 0);
        chk("reset_dout0", gen[0].dout, 0);
        @(posedge clk); #1;
        rst_n = 2'b11;
        @(negedge clk);
        chk("idle_ready0", gen[0].rdy, 1);
        chk("idle_busy0", gen[0].bsy, 0);

        // One pixel then no data: underrun after 24 bits, latch, frame_done.
        @(posedge clk); #1;
        valid[0] = 1'b1; data[0] = 32'hFF0000;
        wait_xfer(0, 10);
        valid[0] = 1'b0;
        wait_frame(0, 20000);
        chk("t1_underrun_t", gen[0].ud_t, 1511);
        chk("t1_underrun_cnt", gen[0].ud_cnt, 1);
        chk("t1_frame_done_t", gen[0].fd_t, 16511);
        chk("t1_hi_bit0", hi(0, 0), 43);
        chk("t1_hi_bit7", hi(0, 7), 43);
        chk("t1_hi_bit8", hi(0, 8), 21);
        chk("t1_hi_bit23", hi(0, 23), 21);

        // Two back-to-back pixels, valid held high through the latch period.
        @(posedge clk); #1;
        valid[0] = 1'b1; data[0] = 32'h000001;
        wait_xfer(0, 10);
        data[0] = 32'h800000;
        wait_xfer(0, 2000);
        data[0] = 32'h5A5A5A;
        wait_frame(0, 20000);
        chk("t2_xfers", gen[0].xfer_cnt, 2);
        chk("t2_no_underrun", gen[0].ud_cnt, 0);
        chk("t2_frame_done_t", gen[0].fd_t, 18023);
        chk("t2_hi_bit22", hi(0, 22), 21);
        chk("t2_hi_bit23", hi(0, 23), 43);
        chk("t2_hi_bit24", hi(0, 24), 43);
        chk("t2_hi_bit47", hi(0, 47), 21);
        chk("t3_ready_in_latch", gen[0].rdy, 0);
        wait_xfer(0, 3);
        chk("t3_restart_cycle", gen[0].xf_cyc, gen[0].fd_cyc + 1);
        valid[0] = 1'b0;

        // Reset in the middle of a '1' bit (0x5A: second bit is '1').
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk); #2;
            if (gen[0].t_cur == 73) hit = 1'b1;
        end
        chk("t4_reached_bit1", hit, 1);
        chk("t4_dout_before", gen[0].dout, 1);
        rst_n[0] = 1'b0;
        #1;
        chk("t4_dout_reset", gen[0].dout, 0);
        chk("t4_busy_reset", gen[0].bsy, 0);
        repeat (3) @(posedge clk);
        #1;
        d0 = gen[0].done_cnt;
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("t4_ready_after", gen[0].rdy, 1);
        repeat (100) @(posedge clk);
        chk("t4_no_frame_done", gen[0].done_cnt, d0);

        // 32-bit pixel with fast timing.
        @(posedge clk); #1;
        valid[1] = 1'b1; data[1] = 32'hAAAAAAAA;
        wait_xfer(1, 10);
        valid[1] = 1'b0;
        wait_frame(1, 1000);
        chk("t5_underrun_t", gen[1].ud_t, 319);
        chk("t5_frame_done_t", gen[1].fd_t, 339);
        chk("t5_hi_bit0", hi(1, 0), 7);
        chk("t5_hi_bit1", hi(1, 1), 3);
        chk("t5_hi_bit31", hi(1, 31), 3);
        tot = 0;
        for (int k = 0; k < 34; k++) tot += hi(1, k);
        chk("t5_total_high", tot, 160);

        // Random stream with gaps and one mid-run reset.
        d0 = gen[1].done_cnt;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            valid[1] = ($urandom_range(0, 99) < 85);
            data[1]  = $urandom;
            if (i == 2000) rst_n[1] = 1'b0;
            if (i == 2002) rst_n[1] = 1'b1;
        end
        valid[1] = 1'b0;
        repeat (1100) @(posedge clk);
        chk("rand_frames_seen", (gen[1].done_cnt - d0) >= 2, 1);
        chk("rand_idle_at_end", gen[1].bsy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
